// File: rtl/rf_wport_arb.sv
// Register-file write-port arbiter: WB stage vs. multi-cycle unit results (FIFO + scoreboard).
// Optional macro RF_WPORT_BYPASS_EN adds head-of-FIFO forwarding ports for decode.
module rf_wport_arb #(
  parameter int FIFO_DEPTH = 2,
  parameter int STARVE_MAX = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wb_we,
  input  logic [4:0]  wb_w_addr,
  input  logic [31:0] wb_w_data,
  output logic        wb_stall,
  input  logic        mu_valid,
  output logic        mu_ready,
  input  logic [4:0]  mu_w_addr,
  input  logic [31:0] mu_w_data,
  input  logic        mu_issue,
  input  logic [4:0]  mu_issue_addr,
  input  logic [4:0]  rs_a_addr,
  input  logic [4:0]  rs_b_addr,
  output logic        rs_a_busy,
  output logic        rs_b_busy,
`ifdef RF_WPORT_BYPASS_EN
  output logic        rs_a_fwd_sel,
  output logic        rs_b_fwd_sel,
  output logic [31:0] rs_fwd_data,
`endif
  output logic        rf_we,
  output logic [4:0]  rf_w_addr,
  output logic [31:0] rf_w_data
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int SC_W  = $clog2(STARVE_MAX + 1);

  logic [4:0]       fifo_addr_mem [FIFO_DEPTH];
  logic [31:0]      fifo_data_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [CNT_W-1:0] count_reg;
  logic [SC_W-1:0]  starve_reg;
  logic [31:0]      sb_reg;
  logic             rf_we_reg;
  logic [4:0]       rf_w_addr_reg;
  logic [31:0]      rf_w_data_reg;

  logic        fifo_empty;
  logic        fifo_full;
  logic        push;
  logic        force_pop;
  logic        grant_fifo;
  logic        grant_wb;
  logic [4:0]  head_addr;
  logic [31:0] head_data;
  logic [4:0]  grant_addr;
  logic [31:0] grant_data;
  logic [31:0] set_mask;
  logic [31:0] clr_mask;

  assign fifo_empty = (count_reg == '0);
  assign fifo_full  = (count_reg == CNT_W'(FIFO_DEPTH));
  // Readiness comes from the registered count only, so a same-cycle pop never frees a slot early.
  assign mu_ready   = !fifo_full;
  assign push       = mu_valid && mu_ready;
  assign force_pop  = (starve_reg == SC_W'(STARVE_MAX)) && !fifo_empty;
  assign head_addr  = fifo_addr_mem[rd_ptr_reg];
  assign head_data  = fifo_data_mem[rd_ptr_reg];

  always_comb begin
    grant_fifo = 1'b0;
    grant_wb   = 1'b0;
    wb_stall   = 1'b0;
    if (force_pop) begin
      grant_fifo = 1'b1;
      wb_stall   = wb_we;
    end else if (wb_we) begin
      grant_wb   = 1'b1;
    end else if (!fifo_empty) begin
      grant_fifo = 1'b1;
    end
  end

  assign grant_addr = grant_fifo ? head_addr : wb_w_addr;
  assign grant_data = grant_fifo ? head_data : wb_w_data;

  // Per-bit scoreboard masks; R31 is hardwired zero and never tracked.
  genvar gi;
  generate
    for (gi = 0; gi < 31; gi++) begin : g_set
      assign set_mask[gi] = mu_issue && (mu_issue_addr == 5'(gi));
    end
    for (gi = 0; gi < 32; gi++) begin : g_clr
      assign clr_mask[gi] = grant_fifo && (head_addr == 5'(gi));
    end
  endgenerate
  assign set_mask[31] = 1'b0;

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_addr_mem[wr_ptr_reg] <= mu_w_addr;
      fifo_data_mem[wr_ptr_reg] <= mu_w_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      count_reg     <= '0;
      starve_reg    <= '0;
      sb_reg        <= '0;
      rf_we_reg     <= 1'b0;
      rf_w_addr_reg <= '0;
      rf_w_data_reg <= '0;
    end else begin
      if (push)
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (grant_fifo)
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({push, grant_fifo})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
      if (grant_fifo || fifo_empty)
        starve_reg <= '0;
      else if (grant_wb && (starve_reg != SC_W'(STARVE_MAX)))
        starve_reg <= starve_reg + 1'b1;
      // Set after clear so a re-issue in the commit cycle keeps the register pending.
      sb_reg    <= (sb_reg & ~clr_mask) | set_mask;
      rf_we_reg <= (grant_fifo || grant_wb) && (grant_addr != 5'd31);
      if (grant_fifo || grant_wb) begin
        rf_w_addr_reg <= grant_addr;
        rf_w_data_reg <= grant_data;
      end
    end
  end

  assign rf_we     = rf_we_reg;
  assign rf_w_addr = rf_w_addr_reg;
  assign rf_w_data = rf_w_data_reg;

`ifdef RF_WPORT_BYPASS_EN
  assign rs_a_fwd_sel = grant_fifo && (head_addr == rs_a_addr) && (head_addr != 5'd31);
  assign rs_b_fwd_sel = grant_fifo && (head_addr == rs_b_addr) && (head_addr != 5'd31);
  assign rs_fwd_data  = head_data;
  assign rs_a_busy    = sb_reg[rs_a_addr] && !rs_a_fwd_sel;
  assign rs_b_busy    = sb_reg[rs_b_addr] && !rs_b_fwd_sel;
`else
  assign rs_a_busy = sb_reg[rs_a_addr];
  assign rs_b_busy = sb_reg[rs_b_addr];
`endif

endmodule

// File: tb/tb_rf_wport_arb.sv
// Bench for rf_wport_arb: directed scenarios with literal checks plus randomized traffic
// checked every cycle against a queue-based model of the write-port rules.
module tb_rf_wport_arb;
  localparam int DEPTH = 2;
  localparam int SMAX  = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wb_we = 1'b0;
  logic [4:0]  wb_w_addr = '0;
  logic [31:0] wb_w_data = '0;
  logic        wb_stall;
  logic        mu_valid = 1'b0;
  logic        mu_ready;
  logic [4:0]  mu_w_addr = '0;
  logic [31:0] mu_w_data = '0;
  logic        mu_issue = 1'b0;
  logic [4:0]  mu_issue_addr = '0;
  logic [4:0]  rs_a_addr = '0;
  logic [4:0]  rs_b_addr = '0;
  logic        rs_a_busy;
  logic        rs_b_busy;
  logic        rf_we;
  logic [4:0]  rf_w_addr;
  logic [31:0] rf_w_data;

  rf_wport_arb #(.FIFO_DEPTH(DEPTH), .STARVE_MAX(SMAX)) dut (
    .clk(clk), .rst_n(rst_n),
    .wb_we(wb_we), .wb_w_addr(wb_w_addr), .wb_w_data(wb_w_data), .wb_stall(wb_stall),
    .mu_valid(mu_valid), .mu_ready(mu_ready), .mu_w_addr(mu_w_addr), .mu_w_data(mu_w_data),
    .mu_issue(mu_issue), .mu_issue_addr(mu_issue_addr),
    .rs_a_addr(rs_a_addr), .rs_b_addr(rs_b_addr), .rs_a_busy(rs_a_busy), .rs_b_busy(rs_b_busy),
    .rf_we(rf_we), .rf_w_addr(rf_w_addr), .rf_w_data(rf_w_data)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0]  a;
    logic [31:0] d;
  } ent_t;

  // Reference model state
  ent_t        q[$];
  int          starve_m;
  bit [31:0]   pend_m;
  bit          m_we;
  logic [4:0]  m_addr;
  logic [31:0] m_data;
  bit          m_rdy_last;
  bit          m_stall_last;

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: actual %0h required %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    starve_m = 0;
    pend_m = '0;
    m_we = 1'b0;
    m_addr = '0;
    m_data = '0;
    m_rdy_last = 1'b1;
    m_stall_last = 1'b0;
  endtask

  // Called just after a falling edge with inputs applied; checks, advances model, returns at next falling edge.
  task automatic cycle();
    bit emp, frc, gf, gw;
    ent_t h;
    logic [4:0]  ga;
    logic [31:0] gd;
    #1;
    emp = (q.size() == 0);
    frc = (starve_m == SMAX) && !emp;
    chk("mu_ready", mu_ready, q.size() < DEPTH);
    chk("wb_stall", wb_stall, frc && wb_we);
    chk("rs_a_busy", rs_a_busy, pend_m[rs_a_addr]);
    chk("rs_b_busy", rs_b_busy, pend_m[rs_b_addr]);
    chk("rf_we", rf_we, m_we);
    if (m_we) begin
      chk("rf_w_addr", rf_w_addr, m_addr);
      chk("rf_w_data", rf_w_data, m_data);
    end
    m_rdy_last = (q.size() < DEPTH);
    m_stall_last = frc && wb_we;
    gf = frc || (!wb_we && !emp);
    gw = wb_we && !frc;
    ga = wb_w_addr;
    gd = wb_w_data;
    if (gf) begin
      h = q.pop_front();
      ga = h.a;
      gd = h.d;
      pend_m[h.a] = 1'b0;
    end
    if (gf || gw) begin
      m_we = (ga != 5'd31);
      m_addr = ga;
      m_data = gd;
      $display("t=%0t grant %s r%0d = %h%s", $time, gf ? "MU" : "WB", ga, gd, m_we ? "" : " (dropped)");
    end else begin
      m_we = 1'b0;
    end
    if (mu_issue && mu_issue_addr != 5'd31) pend_m[mu_issue_addr] = 1'b1;
    if (mu_valid && m_rdy_last) q.push_back({mu_w_addr, mu_w_data});
    if (gf || emp) starve_m = 0;
    else if (gw && starve_m < SMAX) starve_m++;
    @(negedge clk);
  endtask

  task automatic do_reset();
    wb_we = 1'b0; mu_valid = 1'b0; mu_issue = 1'b0;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("rst_rf_we", rf_we, 0);
    chk("rst_rf_w_addr", rf_w_addr, 0);
    chk("rst_rf_w_data", rf_w_data, 0);
    chk("rst_mu_ready", mu_ready, 1);
    chk("rst_wb_stall", wb_stall, 0);
    for (int i = 0; i < 32; i++) begin
      rs_a_addr = 5'(i);
      #1;
      chk("rst_rs_a_busy", rs_a_busy, 0);
    end
    rs_a_addr = '0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic issue(input logic [4:0] a);
    mu_issue = 1'b1; mu_issue_addr = a;
    cycle();
    mu_issue = 1'b0;
  endtask

  initial begin
    int nr;
    logic [4:0] iss[$];
    logic [4:0] a;
    bit mu_hold, wb_hold;

    @(negedge clk);
    do_reset();

    // WB write
    wb_we = 1'b1; wb_w_addr = 5'd5; wb_w_data = 32'hDEADBEEF;
    chk("wb_lit_stall", wb_stall, 0);
    cycle();
    wb_we = 1'b0;
    chk("wb_lit_we", rf_we, 1);
    chk("wb_lit_addr", rf_w_addr, 5);
    chk("wb_lit_data", rf_w_data, 32'hDEADBEEF);

    // MU drain of R7
    rs_a_addr = 5'd7;
    issue(5'd7);
    for (int i = 0; i < 3; i++) begin
      chk("drain_busy_wait", rs_a_busy, 1);
      cycle();
    end
    mu_valid = 1'b1; mu_w_addr = 5'd7; mu_w_data = 32'h1234;
    cycle();
    mu_valid = 1'b0;
    chk("drain_busy_grant", rs_a_busy, 1);
    cycle();
    chk("drain_rf_we", rf_we, 1);
    chk("drain_rf_addr", rf_w_addr, 7);
    chk("drain_rf_data", rf_w_data, 32'h1234);
    chk("drain_busy_after", rs_a_busy, 0);
    cycle();

    // Starvation: R3 waits behind 8 WB grants
    issue(5'd3);
    wb_we = 1'b1; wb_w_addr = 5'd9; wb_w_data = 32'h9;
    mu_valid = 1'b1; mu_w_addr = 5'd3; mu_w_data = 32'h33;
    cycle();
    mu_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      wb_w_addr = 5'(10 + i); wb_w_data = 32'(100 + i);
      chk("starve_no_stall", wb_stall, 0);
      cycle();
      chk("starve_wb_addr", rf_w_addr, 10 + i);
    end
    wb_w_addr = 5'd20; wb_w_data = 32'h2020;
    chk("starve_stall", wb_stall, 1);
    cycle();
    chk("starve_stall_once", wb_stall, 0);
    chk("starve_r3_addr", rf_w_addr, 3);
    chk("starve_r3_data", rf_w_data, 32'h33);
    cycle();
    wb_we = 1'b0;
    chk("starve_held_addr", rf_w_addr, 20);
    chk("starve_held_data", rf_w_data, 32'h2020);
    cycle();

    // Full FIFO
    issue(5'd11); issue(5'd12); issue(5'd13);
    wb_we = 1'b1; wb_w_addr = 5'd2; wb_w_data = 32'h22;
    mu_valid = 1'b1; mu_w_addr = 5'd11; mu_w_data = 32'hB;
    cycle();
    mu_w_addr = 5'd12; mu_w_data = 32'hC;
    cycle();
    mu_w_addr = 5'd13; mu_w_data = 32'hD;
    nr = 0;
    for (int k = 0; k < 30; k++) begin
      if (mu_ready) break;
      nr++;
      cycle();
    end
    chk("full_ready_low_cycles", nr, 8);
    cycle();
    mu_valid = 1'b0; wb_we = 1'b0;
    for (int i = 0; i < 4; i++) cycle();

    // R31 result is popped but not written
    rs_b_addr = 5'd31;
    issue(5'd31);
    mu_valid = 1'b1; mu_w_addr = 5'd31; mu_w_data = 32'h31;
    cycle();
    mu_valid = 1'b0;
    chk("r31_busy", rs_b_busy, 0);
    cycle();
    chk("r31_rf_we", rf_we, 0);
    cycle();
    chk("r31_mu_ready", mu_ready, 1);

    // Re-issue R4 in its commit cycle
    rs_a_addr = 5'd4;
    issue(5'd4);
    mu_valid = 1'b1; mu_w_addr = 5'd4; mu_w_data = 32'h44;
    cycle();
    mu_valid = 1'b0;
    mu_issue = 1'b1; mu_issue_addr = 5'd4;
    cycle();
    mu_issue = 1'b0;
    chk("setclr_busy", rs_a_busy, 1);
    chk("setclr_rf_addr", rf_w_addr, 4);
    cycle();

    // Reset mid-run with two queued entries
    issue(5'd14); issue(5'd15);
    wb_we = 1'b1; wb_w_addr = 5'd1; wb_w_data = 32'h1;
    mu_valid = 1'b1; mu_w_addr = 5'd14; mu_w_data = 32'hE;
    cycle();
    mu_w_addr = 5'd15; mu_w_data = 32'hF;
    cycle();
    chk("pre_reset_full", mu_ready, 0);
    do_reset();
    for (int i = 0; i < 4; i++) begin
      chk("post_reset_no_write", rf_we, 0);
      cycle();
    end

    // Randomized traffic
    iss.delete();
    mu_hold = 1'b0; wb_hold = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      if (c == 1500) begin
        do_reset();
        iss.delete();
        mu_hold = 1'b0; wb_hold = 1'b0;
      end
      if (!wb_hold) begin
        wb_we = ($urandom_range(0, 99) < (((c / 300) % 2) ? 92 : 45));
        wb_w_addr = 5'($urandom);
        wb_w_data = $urandom;
      end
      if (!mu_hold) begin
        if (iss.size() > 0 && $urandom_range(0, 3) == 0) begin
          mu_valid = 1'b1; mu_w_addr = iss[0]; mu_w_data = $urandom;
        end else begin
          mu_valid = 1'b0;
        end
      end
      a = 5'($urandom_range(0, 31));
      mu_issue = (iss.size() < 3) && !pend_m[a] && ($urandom_range(0, 2) == 0);
      mu_issue_addr = a;
      if (mu_issue) iss.push_back(a);
      rs_a_addr = ($urandom_range(0, 1) && iss.size() > 0) ? iss[iss.size() - 1] : 5'($urandom);
      rs_b_addr = 5'($urandom);
      cycle();
      if (mu_valid && m_rdy_last) void'(iss.pop_front());
      mu_hold = mu_valid && !m_rdy_last;
      wb_hold = m_stall_last;
    end
    mu_issue = 1'b0; mu_valid = 1'b0; wb_we = 1'b0;
    for (int i = 0; i < 4; i++) cycle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
